// File: rtl/uart_tx_arbiter_if.sv
// Bus bundle between the two TX FIFO read sides, the UART transmitter
// and the arbiter. slave = arbiter view, master = environment view.
//   src0_*/src1_* : FIFO head word, not-empty flag, pop strobe
//   tx_*          : transmitter ready, start strobe, transmitted word
//   grant_o/active_o/sent_cnt_o : arbiter status
interface uart_tx_arbiter_if #(
    parameter int p_word_size = 8,
    parameter int p_cnt_width = 16
);
    logic [p_word_size-1:0] src0_data_i;
    logic                   src0_valid_i;
    logic                   src0_read_o;
    logic [p_word_size-1:0] src1_data_i;
    logic                   src1_valid_i;
    logic                   src1_read_o;
    logic                   tx_ready_i;
    logic                   tx_start_o;
    logic [p_word_size-1:0] tx_data_o;
    logic                   grant_o;
    logic                   active_o;
    logic [p_cnt_width-1:0] sent_cnt_o;

    modport slave (
        input  src0_data_i, src0_valid_i,
        input  src1_data_i, src1_valid_i,
        input  tx_ready_i,
        output src0_read_o, src1_read_o,
        output tx_start_o, tx_data_o,
        output grant_o, active_o, sent_cnt_o
    );

    modport master (
        output src0_data_i, src0_valid_i,
        output src1_data_i, src1_valid_i,
        output tx_ready_i,
        input  src0_read_o, src1_read_o,
        input  tx_start_o, tx_data_o,
        input  grant_o, active_o, sent_cnt_o
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter draining two TX FIFOs into one UART transmitter,
// one word per transmitter handshake, bursts bounded to p_burst_max.
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus          : uart_tx_arbiter_if.slave (FIFO, transmitter, status)
module uart_tx_arbiter #(
    parameter int p_word_size = 8,
    parameter int p_burst_max = 4,
    parameter int p_cnt_width = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    uart_tx_arbiter_if.slave   bus
);
    localparam int c_bw = $clog2(p_burst_max + 1);
    localparam logic [c_bw-1:0] c_burst_max = c_bw'(p_burst_max);

    typedef enum logic [1:0] {
        s_idle,
        s_send,
        s_hold
    } state_t;

    state_t                 r_state;
    logic                   r_grant;
    logic                   r_last_grant;
    logic [c_bw-1:0]        r_burst_cnt;
    logic [p_cnt_width-1:0] r_sent_cnt;

    logic w_valid_g;
    logic w_valid_o;
    logic w_fire;

    assign w_valid_g = r_grant ? bus.src1_valid_i : bus.src0_valid_i;
    assign w_valid_o = r_grant ? bus.src0_valid_i : bus.src1_valid_i;
    assign w_fire    = (r_state == s_send) & bus.tx_ready_i & w_valid_g;

    // Pop and start are the same handshake, so a word is never popped
    // without being handed to the transmitter.
    assign bus.tx_start_o  = w_fire;
    assign bus.src0_read_o = w_fire & ~r_grant;
    assign bus.src1_read_o = w_fire & r_grant;
    assign bus.tx_data_o   = r_grant ? bus.src1_data_i : bus.src0_data_i;
    assign bus.grant_o     = r_grant;
    assign bus.active_o    = (r_state != s_idle);
    assign bus.sent_cnt_o  = r_sent_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= s_idle;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_burst_cnt  <= '0;
            r_sent_cnt   <= '0;
        end else begin
            unique case (r_state)
                s_idle: begin
                    if (bus.src0_valid_i | bus.src1_valid_i) begin
                        // Tie goes to whoever was not served last.
                        if (bus.src0_valid_i & bus.src1_valid_i)
                            r_grant <= ~r_last_grant;
                        else
                            r_grant <= bus.src1_valid_i;
                        r_burst_cnt <= '0;
                        r_state     <= s_send;
                    end
                end
                s_send: begin
                    if (w_fire) begin
                        r_burst_cnt <= r_burst_cnt + c_bw'(1);
                        r_sent_cnt  <= r_sent_cnt + p_cnt_width'(1);
                        r_state     <= s_hold;
                    end else if (!w_valid_g) begin
                        r_last_grant <= r_grant;
                        r_state      <= s_idle;
                    end
                end
                s_hold: begin
                    // One dead cycle lets the FIFO pointer and
                    // tx_ready_i reflect the word just started.
                    if (w_valid_g &&
                        (r_burst_cnt < c_burst_max || !w_valid_o)) begin
                        if (r_burst_cnt == c_burst_max)
                            r_burst_cnt <= '0;
                        r_state <= s_send;
                    end else if (w_valid_o) begin
                        r_grant     <= ~r_grant;
                        r_burst_cnt <= '0;
                        r_state     <= s_send;
                    end else begin
                        r_last_grant <= r_grant;
                        r_state      <= s_idle;
                    end
                end
                default: r_state <= s_idle;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: queue-modelled FIFOs feed the
// arbiter, expected {grant,data} pairs are matched on each tx_start_o.
module tb_uart_tx_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.p_word_size(8), .p_cnt_width(4)) bus ();

    uart_tx_arbiter #(
        .p_word_size(8),
        .p_burst_max(4),
        .p_cnt_width(4)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [8:0] expq[$];
    int checks = 0;
    int errors = 0;
    int model_cnt = 0;
    logic p0, p1;

    function automatic void refresh();
        bus.src0_valid_i = (q0.size() > 0);
        bus.src0_data_i  = (q0.size() > 0) ? q0[0] : 8'h00;
        bus.src1_valid_i = (q1.size() > 0);
        bus.src1_data_i  = (q1.size() > 0) ? q1[0] : 8'h00;
    endfunction

    function automatic void exp_word(bit g, logic [7:0] d);
        expq.push_back({g, d});
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // FIFO model: pops on the strobe seen at the edge.
    always @(posedge clk) begin
        p0 = bus.src0_read_o;
        p1 = bus.src1_read_o;
        #1;
        if (p0 && q0.size() > 0) void'(q0.pop_front());
        if (p1 && q1.size() > 0) void'(q1.pop_front());
        refresh();
    end

    // Monitor: pops the scoreboard on every start strobe.
    always @(negedge clk) begin
        logic [8:0] e;
        if (rst) begin
            model_cnt = 0;
        end else if (bus.tx_start_o) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_start: got data %0h expected none",
                         bus.tx_data_o);
            end else begin
                e = expq.pop_front();
                chk("tx_data", 32'(bus.tx_data_o), 32'(e[7:0]));
                chk("grant", 32'(bus.grant_o), 32'(e[8]));
            end
            chk("sent_cnt", 32'(bus.sent_cnt_o), 32'(model_cnt));
            model_cnt = (model_cnt + 1) % 16;
            chk("read_strobes", 32'({bus.src1_read_o, bus.src0_read_o}),
                bus.grant_o ? 32'd2 : 32'd1);
        end else begin
            chk("idle_strobes", 32'({bus.src1_read_o, bus.src0_read_o}), 0);
        end
    end

    task automatic wait_idle(int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (!bus.active_o && q0.size() == 0 && q1.size() == 0 &&
                expq.size() == 0)
                done = 1'b1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL drain_timeout: got %0d words left expected 0",
                     expq.size());
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        bus.tx_ready_i = 1'b1;
        refresh();
        @(posedge clk);
        #1;
        chk("rst_active", 32'(bus.active_o), 0);
        chk("rst_grant", 32'(bus.grant_o), 0);
        chk("rst_sent", 32'(bus.sent_cnt_o), 0);
        chk("rst_start", 32'(bus.tx_start_o), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // single source, back-to-back every 2 cycles
        @(posedge clk);
        #1;
        q0 = '{8'hA1, 8'hB2, 8'hC3};
        exp_word(0, 8'hA1);
        exp_word(0, 8'hB2);
        exp_word(0, 8'hC3);
        refresh();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("t1_start", 32'(bus.tx_start_o),
                32'(k == 1 || k == 3 || k == 5));
        end
        chk("t1_sent", 32'(bus.sent_cnt_o), 3);
        chk("t1_active", 32'(bus.active_o), 0);
        wait_idle(20);

        // both sources loaded, burst limit 4
        do_reset();
        for (int i = 0; i < 6; i++) begin
            q0.push_back(8'h20 + 8'(i));
            q1.push_back(8'h40 + 8'(i));
        end
        for (int i = 0; i < 4; i++) exp_word(0, 8'h20 + 8'(i));
        for (int i = 0; i < 4; i++) exp_word(1, 8'h40 + 8'(i));
        exp_word(0, 8'h24);
        exp_word(0, 8'h25);
        exp_word(1, 8'h44);
        exp_word(1, 8'h45);
        refresh();
        wait_idle(100);

        // transmitter busy: hold in SEND with no strobes
        bus.tx_ready_i = 1'b0;
        q0.push_back(8'h55);
        exp_word(0, 8'h55);
        refresh();
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("t3_start", 32'(bus.tx_start_o), 0);
            chk("t3_data", 32'(bus.tx_data_o), 32'h55);
            chk("t3_active", 32'(bus.active_o), 1);
        end
        bus.tx_ready_i = 1'b1;
        wait_idle(20);

        // tie-break follows last served source
        q1.push_back(8'h71);
        exp_word(1, 8'h71);
        refresh();
        wait_idle(20);
        q0.push_back(8'h80);
        q1.push_back(8'h81);
        exp_word(0, 8'h80);
        exp_word(1, 8'h81);
        refresh();
        wait_idle(20);
        q0.push_back(8'h90);
        exp_word(0, 8'h90);
        refresh();
        wait_idle(20);
        q0.push_back(8'hA0);
        q1.push_back(8'hA1);
        exp_word(1, 8'hA1);
        exp_word(0, 8'hA0);
        refresh();
        wait_idle(20);

        // reset during HOLD keeps the remaining words
        q0 = '{8'hC0, 8'hC1, 8'hC2};
        exp_word(0, 8'hC0);
        exp_word(0, 8'hC1);
        exp_word(0, 8'hC2);
        refresh();
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clk);
                seen = bus.tx_start_o;
            end
            chk("t5_first_start", 32'(seen), 1);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_active", 32'(bus.active_o), 0);
        chk("t5_grant", 32'(bus.grant_o), 0);
        chk("t5_sent", 32'(bus.sent_cnt_o), 0);
        chk("t5_start", 32'(bus.tx_start_o), 0);
        chk("t5_fifo_left", 32'(q0.size()), 2);
        rst = 1'b0;
        wait_idle(20);
        chk("t5_sent_after", 32'(bus.sent_cnt_o), 2);

        // 4-bit counter wraps after 16 words
        do_reset();
        for (int i = 0; i < 17; i++) begin
            q0.push_back(8'(i) + 8'h01);
            exp_word(0, 8'(i) + 8'h01);
        end
        refresh();
        wait_idle(100);
        chk("t6_sent_wrap", 32'(bus.sent_cnt_o), 1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
